// File: rtl/move_committer.sv
// Move committer: snapshots a candidate board from the updater, scans it
// against the committed board, then commits or rejects the move.
// Ports:
//   clk_in, rst_in (sync, active-high)
//   board_ready, next_board, move_in        candidate move from the updater
//   board_bus, turn                         committed position
//   busy, commit_pulse, reject_pulse        progress and outcome strobes
//   black_captures, white_captures          saturating capture totals
// Optional feature macro: KO_CHECK_EN (simple ko rejection via hist_board).
module move_committer (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  board_ready,
    input  logic [1:0][8:0][8:0]  next_board,
    input  logic [7:0]            move_in,
    output logic [1:0][8:0][8:0]  board_bus,
    output logic                  turn,
    output logic                  busy,
    output logic                  commit_pulse,
    output logic                  reject_pulse,
    output logic [7:0]            black_captures,
    output logic [7:0]            white_captures
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0][8:0][8:0] snap;
    logic [3:0]           mv_row;
    logic [3:0]           mv_col;
    logic                 mv_in_range;
    logic                 mv_occupied;
    logic                 mv_placed;
    logic [6:0]           scan_idx;
    logic [3:0]           scan_row;
    logic [3:0]           scan_col;
    logic [6:0]           cap_cnt;
    logic                 accept_q;

    logic                 take_move;
    logic                 accept;
    logic                 ko_hit;
    logic [1:0]           mover;
    logic [1:0]           opponent;
    logic [1:0]           bus_cell;
    logic [1:0]           snap_cell;
    logic                 at_move;

    function automatic logic [1:0] cell_of(
        input logic [1:0][8:0][8:0] b,
        input logic [3:0]           r,
        input logic [3:0]           c
    );
        return {b[1][r][c], b[0][r][c]};
    endfunction

    function automatic logic [7:0] sat_add(
        input logic [7:0] a,
        input logic [6:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign mover     = {turn, ~turn};
    assign opponent  = {~turn, turn};
    assign bus_cell  = cell_of(board_bus, scan_row, scan_col);
    assign snap_cell = cell_of(snap, scan_row, scan_col);
    assign at_move   = (scan_row == mv_row) && (scan_col == mv_col);

`ifdef KO_CHECK_EN
    logic [1:0][8:0][8:0] hist_board;
    logic                 ko_match;
    logic [1:0]           hist_cell;

    assign hist_cell = cell_of(hist_board, scan_row, scan_col);
    assign ko_hit    = ko_match;

    // hist_board holds the position just before the latest commit; a
    // snapshot identical to it would recreate that position (simple ko).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hist_board <= '0;
            ko_match   <= 1'b0;
        end else begin
            if (take_move) begin
                ko_match <= 1'b1;
            end else if (state == SCAN && snap_cell != hist_cell) begin
                ko_match <= 1'b0;
            end
            if (state == DECIDE && accept) begin
                hist_board <= board_bus;
            end
        end
    end
`else
    assign ko_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_move  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (board_ready) begin
                    state_next = SCAN;
                    take_move  = 1'b1;
                end
            end
            SCAN: begin
                if (scan_idx == 7'd80) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                state_next = REPORT;
                accept     = mv_in_range && !mv_occupied &&
                             mv_placed && !ko_hit;
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign commit_pulse = (state == REPORT) && accept_q;
    assign reject_pulse = (state == REPORT) && !accept_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            board_bus      <= '0;
            turn           <= 1'b0;
            black_captures <= 8'd0;
            white_captures <= 8'd0;
            snap           <= '0;
            mv_row         <= 4'd0;
            mv_col         <= 4'd0;
            mv_in_range    <= 1'b0;
            mv_occupied    <= 1'b0;
            mv_placed      <= 1'b0;
            scan_idx       <= 7'd0;
            scan_row       <= 4'd0;
            scan_col       <= 4'd0;
            cap_cnt        <= 7'd0;
            accept_q       <= 1'b0;
        end else begin
            if (take_move) begin
                snap        <= next_board;
                mv_row      <= move_in[7:4];
                mv_col      <= move_in[3:0];
                mv_in_range <= (move_in[7:4] <= 4'd8) &&
                               (move_in[3:0] <= 4'd8);
                mv_occupied <= 1'b0;
                mv_placed   <= 1'b0;
                scan_idx    <= 7'd0;
                scan_row    <= 4'd0;
                scan_col    <= 4'd0;
                cap_cnt     <= 7'd0;
            end

            if (state == SCAN) begin
                // Opponent stone on the committed board, gone in the
                // snapshot: removed by this move.
                if (bus_cell == opponent && snap_cell == 2'b00) begin
                    cap_cnt <= cap_cnt + 7'd1;
                end
                // The move cell is checked as the scan passes it; an
                // out-of-range move never matches and stays rejected.
                if (at_move) begin
                    mv_occupied <= (bus_cell != 2'b00);
                    mv_placed   <= (snap_cell == mover);
                end
                if (scan_idx != 7'd80) begin
                    scan_idx <= scan_idx + 7'd1;
                    if (scan_col == 4'd8) begin
                        scan_col <= 4'd0;
                        scan_row <= scan_row + 4'd1;
                    end else begin
                        scan_col <= scan_col + 4'd1;
                    end
                end
            end

            if (state == DECIDE) begin
                accept_q <= accept;
                if (accept) begin
                    board_bus <= snap;
                    turn      <= ~turn;
                    if (turn) begin
                        white_captures <= sat_add(white_captures, cap_cnt);
                    end else begin
                        black_captures <= sat_add(black_captures, cap_cnt);
                    end
                end
            end
        end
    end

endmodule
